sensor_qualifier: RTL and testbench

SENSOR_QUALIFIER -- requirements
Module: sensor_qualifier

---
 rtl/sensor_qualifier_pkg.sv | 25 ++
 rtl/sensor_qualifier_sync.sv | 26 ++
 rtl/sensor_qualifier.sv | 151 +++++++++++++++
 tb/tb_sensor_qualifier.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/sensor_qualifier_pkg.sv
// Shared traffic package: light encodings for the controller, plus the
// sensor qualifier's state encoding and default timing parameters.
package sensor_qualifier_pkg;

    typedef enum logic [1:0] {
        LIGHT_GREEN  = 2'b00,
        LIGHT_YELLOW = 2'b01,
        LIGHT_RED    = 2'b10
    } light_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_QUAL_ON  = 3'd1,
        ST_PRESENT  = 3'd2,
        ST_QUAL_OFF = 3'd3,
        ST_FAULT    = 3'd4
    } qual_state_t;

    localparam int unsigned DEF_SYNC_STAGES  = 2;
    localparam int unsigned DEF_ON_CYCLES    = 8;
    localparam int unsigned DEF_OFF_CYCLES   = 16;
    localparam int unsigned DEF_STUCK_CYCLES = 4096;
    localparam int unsigned VCOUNT_W         = 8;

endpackage

// File: rtl/sensor_qualifier_sync.sv
// Multi-flop synchronizer for the asynchronous loop-detector contact.
module sensor_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    // Fewer than two stages would not give metastability settling time.
    localparam int unsigned N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [N-1:0] sr;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sr <= '0;
        end else begin
            sr <= {sr[N-2:0], d};
        end
    end

    assign q = sr[N-1];

endmodule

// File: rtl/sensor_qualifier.sv
// Debounces the farm-road loop detector into a clean vehicle-demand signal,
// counts arrivals and flags a detector stuck in the present state.
module sensor_qualifier
    import sensor_qualifier_pkg::*;
#(
    parameter int unsigned SYNC_STAGES  = DEF_SYNC_STAGES,
    parameter int unsigned ON_CYCLES    = DEF_ON_CYCLES,
    parameter int unsigned OFF_CYCLES   = DEF_OFF_CYCLES,
    parameter int unsigned STUCK_CYCLES = DEF_STUCK_CYCLES
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                raw_sensor,
    output logic                sensor,
    output logic                fault,
    output logic [VCOUNT_W-1:0] vehicle_count
);

    localparam int unsigned QMAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int unsigned QW   = $clog2(QMAX + 1);
    localparam int unsigned SW   = $clog2(STUCK_CYCLES + 1);

    localparam logic [QW-1:0]       ON_LIM    = QW'(ON_CYCLES);
    localparam logic [QW-1:0]       OFF_LIM   = QW'(OFF_CYCLES);
    localparam logic [SW-1:0]       STUCK_LIM = SW'(STUCK_CYCLES);
    localparam logic [VCOUNT_W-1:0] VC_MAX    = '1;

    qual_state_t   state;
    logic [QW-1:0] q_cnt;
    logic [QW-1:0] q_inc;
    logic [SW-1:0] stuck_cnt;
    logic          s_sync;
    logic          in_present;
    logic          stuck_hit;

    sensor_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rstn (rstn),
        .d    (raw_sensor),
        .q    (s_sync)
    );

    assign q_inc      = q_cnt + QW'(1);
    assign in_present = (state == ST_PRESENT) || (state == ST_QUAL_OFF);
    assign stuck_hit  = in_present && ((stuck_cnt + SW'(1)) >= STUCK_LIM);

    // Qualification FSM with registered outputs; stuck detection overrides all.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state         <= ST_IDLE;
            q_cnt         <= '0;
            stuck_cnt     <= '0;
            sensor        <= 1'b0;
            fault         <= 1'b0;
            vehicle_count <= '0;
        end else begin
            if (in_present && (stuck_cnt != STUCK_LIM)) begin
                stuck_cnt <= stuck_cnt + SW'(1);
            end

            if (stuck_hit) begin
                state  <= ST_FAULT;
                q_cnt  <= '0;
                sensor <= 1'b1;
                fault  <= 1'b1;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (s_sync) begin
                            if (ON_CYCLES <= 1) begin
                                state  <= ST_PRESENT;
                                q_cnt  <= '0;
                                sensor <= 1'b1;
                                if (vehicle_count != VC_MAX) begin
                                    vehicle_count <= vehicle_count + VCOUNT_W'(1);
                                end
                            end else begin
                                state <= ST_QUAL_ON;
                                q_cnt <= QW'(1);
                            end
                        end
                    end
                    ST_QUAL_ON: begin
                        if (!s_sync) begin
                            state <= ST_IDLE;
                            q_cnt <= '0;
                        end else if (q_inc >= ON_LIM) begin
                            state  <= ST_PRESENT;
                            q_cnt  <= '0;
                            sensor <= 1'b1;
                            if (vehicle_count != VC_MAX) begin
                                vehicle_count <= vehicle_count + VCOUNT_W'(1);
                            end
                        end else begin
                            q_cnt <= q_inc;
                        end
                    end
                    ST_PRESENT: begin
                        if (!s_sync) begin
                            if (OFF_CYCLES <= 1) begin
                                state     <= ST_IDLE;
                                q_cnt     <= '0;
                                stuck_cnt <= '0;
                                sensor    <= 1'b0;
                            end else begin
                                state <= ST_QUAL_OFF;
                                q_cnt <= QW'(1);
                            end
                        end
                    end
                    ST_QUAL_OFF: begin
                        if (s_sync) begin
                            state <= ST_PRESENT;
                            q_cnt <= '0;
                        end else if (q_inc >= OFF_LIM) begin
                            state     <= ST_IDLE;
                            q_cnt     <= '0;
                            stuck_cnt <= '0;
                            sensor    <= 1'b0;
                        end else begin
                            q_cnt <= q_inc;
                        end
                    end
                    ST_FAULT: begin
                        // Any high sample restarts the release window.
                        if (s_sync) begin
                            q_cnt <= '0;
                        end else if (q_inc >= OFF_LIM) begin
                            state     <= ST_IDLE;
                            q_cnt     <= '0;
                            stuck_cnt <= '0;
                            sensor    <= 1'b0;
                            fault     <= 1'b0;
                        end else begin
                            q_cnt <= q_inc;
                        end
                    end
                    default: begin
                        state  <= ST_IDLE;
                        q_cnt  <= '0;
                        sensor <= 1'b0;
                        fault  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sensor_qualifier.sv
// Directed bench for sensor_qualifier with short timing parameters.
module tb_sensor_qualifier;

    logic       clk;
    logic       rstn;
    logic       raw_sensor;
    logic       sensor;
    logic       fault;
    logic [7:0] vehicle_count;

    int n_checks;
    int n_fail;

    sensor_qualifier #(
        .SYNC_STAGES  (2),
        .ON_CYCLES    (4),
        .OFF_CYCLES   (8),
        .STUCK_CYCLES (64)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .raw_sensor    (raw_sensor),
        .sensor        (sensor),
        .fault         (fault),
        .vehicle_count (vehicle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n rising edges, landing 1 time unit after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input int hi, input int lo);
        raw_sensor = 1'b1;
        tick(hi);
        raw_sensor = 1'b0;
        tick(lo);
    endtask

    initial begin
        logic seen_hi;
        logic seen_lo;
        n_checks   = 0;
        n_fail     = 0;
        rstn       = 1'b0;
        raw_sensor = 1'b0;
        tick(3);
        check_eq("reset_sensor", 32'(sensor), 32'd0);
        check_eq("reset_fault", 32'(fault), 32'd0);
        check_eq("reset_count", 32'(vehicle_count), 32'd0);
        rstn = 1'b1;
        tick(2);

        // Clean press: rise 6 edges after first high sample, fall 10 after first low.
        raw_sensor = 1'b1;
        tick(5);
        check_eq("press_edge5_sensor", 32'(sensor), 32'd0);
        tick(1);
        check_eq("press_edge6_sensor", 32'(sensor), 32'd1);
        check_eq("press_count", 32'(vehicle_count), 32'd1);
        tick(14);
        raw_sensor = 1'b0;
        tick(9);
        check_eq("release_edge9_sensor", 32'(sensor), 32'd1);
        tick(1);
        check_eq("release_edge10_sensor", 32'(sensor), 32'd0);
        check_eq("release_count", 32'(vehicle_count), 32'd1);

        // Bounce: 3 high / 1 low never qualifies.
        seen_hi = 1'b0;
        for (int r = 0; r < 10; r++) begin
            raw_sensor = 1'b1;
            for (int k = 0; k < 3; k++) begin
                tick(1);
                seen_hi = seen_hi | sensor;
            end
            raw_sensor = 1'b0;
            tick(1);
            seen_hi = seen_hi | sensor;
        end
        tick(4);
        seen_hi = seen_hi | sensor;
        check_eq("bounce_sensor_never_high", 32'(seen_hi), 32'd0);
        check_eq("bounce_count", 32'(vehicle_count), 32'd1);

        // Dropout ride-through while present.
        raw_sensor = 1'b1;
        tick(10);
        check_eq("dropout_present", 32'(sensor), 32'd1);
        check_eq("dropout_count_before", 32'(vehicle_count), 32'd2);
        seen_lo = 1'b0;
        raw_sensor = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick(1);
            seen_lo = seen_lo | ~sensor;
        end
        raw_sensor = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick(1);
            seen_lo = seen_lo | ~sensor;
        end
        check_eq("dropout_sensor_never_low", 32'(seen_lo), 32'd0);
        check_eq("dropout_count_after", 32'(vehicle_count), 32'd2);
        raw_sensor = 1'b0;
        tick(12);
        check_eq("dropout_release", 32'(sensor), 32'd0);

        // Stuck: PRESENT at edge 6, FAULT 64 cycles later at edge 70.
        raw_sensor = 1'b1;
        tick(69);
        check_eq("stuck_edge69_fault", 32'(fault), 32'd0);
        check_eq("stuck_edge69_sensor", 32'(sensor), 32'd1);
        tick(1);
        check_eq("stuck_edge70_fault", 32'(fault), 32'd1);
        check_eq("stuck_edge70_sensor", 32'(sensor), 32'd1);
        check_eq("stuck_count", 32'(vehicle_count), 32'd3);
        tick(30);
        check_eq("stuck_hold_fault", 32'(fault), 32'd1);
        raw_sensor = 1'b0;
        tick(9);
        check_eq("fault_rel_edge9_fault", 32'(fault), 32'd1);
        check_eq("fault_rel_edge9_sensor", 32'(sensor), 32'd1);
        tick(1);
        check_eq("fault_rel_edge10_fault", 32'(fault), 32'd0);
        check_eq("fault_rel_edge10_sensor", 32'(sensor), 32'd0);
        tick(2);

        // Saturation: 3 + 252 reaches 255, further presses must not wrap.
        for (int p = 0; p < 252; p++) press(8, 12);
        check_eq("sat_reach_255", 32'(vehicle_count), 32'd255);
        for (int p = 0; p < 8; p++) press(8, 12);
        check_eq("sat_hold_255", 32'(vehicle_count), 32'd255);

        // Reset mid-QUAL_ON discards all history.
        raw_sensor = 1'b1;
        tick(3);
        rstn = 1'b0;
        tick(1);
        check_eq("midreset_sensor", 32'(sensor), 32'd0);
        check_eq("midreset_fault", 32'(fault), 32'd0);
        check_eq("midreset_count", 32'(vehicle_count), 32'd0);
        rstn = 1'b1;
        tick(5);
        check_eq("requal_edge5_sensor", 32'(sensor), 32'd0);
        tick(1);
        check_eq("requal_edge6_sensor", 32'(sensor), 32'd1);
        check_eq("requal_count", 32'(vehicle_count), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
